mem_port_arbiter: RTL and testbench

- Shares the single backing-memory port between the I-cache refill path and the D-cache miss/write path of the pipelined RISC-V core.
- Arbitrates between the two requesters and sequences each granted transaction:
  - I-side: a multi-beat line read.
  - D-side: a multi-beat line read, or a single-word write.
- Returns read beats to the owner with a last-beat marker.
- Sits between the two caches and the memory model.

---
 rtl/riscv_mem_pkg.sv | 22 ++
 rtl/mem_arb_select.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and address-offset helpers for the memory-port arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int WORD_OFF_W = 2;

    // Bits of byte offset inside one cache line of `beats` words.
    function automatic int line_off_w(input int beats);
        return $clog2(beats) + WORD_OFF_W;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between the I and D requesters; D wins ties.
// With ARB_FAIRNESS_EN defined, a starve counter lets I win after STARVE_LIMIT D grants.
module mem_arb_select
`ifdef ARB_FAIRNESS_EN
#(
    parameter int STARVE_LIMIT = 3
)
`endif
(
`ifdef ARB_FAIRNESS_EN
    input  logic clock_i,
    input  logic rst_ni,
    input  logic idle_i,
`endif
    input  logic i_req_i,
    input  logic d_req_i,
    output logic sel_i_o,
    output logic sel_d_o
);

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starved;

    assign starved = i_req_i && (starve_q == CNT_W'(STARVE_LIMIT));
    assign sel_d_o = d_req_i && !starved;
    assign sel_i_o = i_req_i && (!d_req_i || starved);

    // Only grants taken in IDLE move the counter; held requests elsewhere are ignored.
    always_comb begin
        starve_d = starve_q;
        if (idle_i && sel_d_o && i_req_i) begin
            starve_d = starve_q + CNT_W'(1);
        end else if (idle_i && sel_i_o) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign sel_d_o = d_req_i;
    assign sel_i_o = i_req_i && !d_req_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache line refills and D-cache line reads / word writes.
// ARB_FAIRNESS_EN enables the I-side starvation guard inside mem_arb_select.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
`ifdef ARB_FAIRNESS_EN
    ,
    parameter int STARVE_LIMIT = 3
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_last,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int LINE_W = line_off_w(BEATS);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              i_gnt_q, i_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              sel_i, sel_d;
    logic              rd_fire, last_beat;
    logic [ADDR_W-1:0] line_addr, word_addr;
    logic              unused_byte_off;

    mem_arb_select
`ifdef ARB_FAIRNESS_EN
        #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
        u_select (
`ifdef ARB_FAIRNESS_EN
        .clock_i (clock),
        .rst_ni  (reset),
        .idle_i  (state_q == IDLE),
`endif
        .i_req_i (i_req),
        .d_req_i (d_req),
        .sel_i_o (sel_i),
        .sel_d_o (sel_d)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        i_gnt_d = 1'b0;
        d_gnt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_d) begin
                    state_d = ISSUE;
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    beat_d  = '0;
                    d_gnt_d = 1'b1;
                end else if (sel_i) begin
                    state_d = ISSUE;
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    beat_d  = '0;
                    i_gnt_d = 1'b1;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    state_d = we_q ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (m_rvalid) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            i_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            i_gnt_q <= i_gnt_d;
            d_gnt_q <= d_gnt_d;
        end
    end

    // Byte offset within a word is never presented to memory.
    assign unused_byte_off = ^addr_q[WORD_OFF_W-1:0];

    assign line_addr = {addr_q[ADDR_W-1:LINE_W], beat_q, WORD_OFF_W'(0)};
    assign word_addr = {addr_q[ADDR_W-1:WORD_OFF_W], WORD_OFF_W'(0)};
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign rd_fire   = (state_q == WAIT_R) && m_rvalid;

    assign m_valid = (state_q == ISSUE);
    assign m_we    = m_valid && we_q;
    assign m_addr  = m_valid ? (we_q ? word_addr : line_addr) : '0;
    assign m_wdata = m_we ? wdata_q : '0;

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = rd_fire && (owner_q == OWN_I);
    assign d_rvalid = rd_fire && (owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;
    assign i_last   = i_rvalid && last_beat;
    assign d_last   = d_rvalid && last_beat;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int BEATS        = 4;
    localparam int STARVE_LIMIT = 3;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        m_ready = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        i_gnt, i_rvalid, i_last, d_gnt, d_rvalid, d_last;
    logic        m_valid, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_last(i_last),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_last(d_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b required %0b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // exp_q holds the memory commands still to be issued for the current transaction.
    logic [31:0] exp_q[$];
    bit          mb, mwait, mwe, gi, gd, take_d;
    logic [31:0] mwd;
    int          starve;

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'(BEATS * 4 - 1);
    endfunction

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            mb = 0; mwait = 0; mwe = 0; gi = 0; gd = 0; mwd = '0; starve = 0;
            exp_q.delete();
        end else begin
            gi = 0; gd = 0;
            if (mb) begin
                if (!mwait) begin
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        if (mwe) mb = 0;
                        else mwait = 1;
                    end
                end else if (m_rvalid) begin
                    mwait = 0;
                    if (exp_q.size() == 0) mb = 0;
                end
            end else if (i_req || d_req) begin
                take_d = d_req && !(FAIR && i_req && starve == STARVE_LIMIT);
                if (take_d) begin
                    gd = 1; mwe = d_we; mwd = d_wdata;
                    if (i_req) starve++;
                    if (d_we) exp_q.push_back(d_addr & ~32'h3);
                    else for (int k = 0; k < BEATS; k++) exp_q.push_back(line_base(d_addr) + 32'(4 * k));
                end else begin
                    gi = 1; mwe = 0; mwd = '0; starve = 0;
                    for (int k = 0; k < BEATS; k++) exp_q.push_back(line_base(i_addr) + 32'(4 * k));
                end
                mb = 1; mwait = 0;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    bit          c_mv, c_rv, c_last;
    logic [31:0] c_addr;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            c_mv   = mb && !mwait;
            c_addr = c_mv ? exp_q[0] : 32'h0;
            c_rv   = mwait && m_rvalid;
            c_last = c_rv && (exp_q.size() == 0);
            chk1 ("busy",     busy,     mb);
            chk1 ("m_valid",  m_valid,  c_mv);
            chk32("m_addr",   m_addr,   c_addr);
            chk1 ("m_we",     m_we,     c_mv && mwe);
            chk32("m_wdata",  m_wdata,  (c_mv && mwe) ? mwd : 32'h0);
            chk1 ("i_gnt",    i_gnt,    gi);
            chk1 ("d_gnt",    d_gnt,    gd);
            chk1 ("i_rvalid", i_rvalid, c_rv && !mwe && gi_owner());
            chk1 ("d_rvalid", d_rvalid, c_rv && !gi_owner());
            chk32("i_rdata",  i_rdata,  (c_rv && gi_owner()) ? m_rdata : 32'h0);
            chk32("d_rdata",  d_rdata,  (c_rv && !gi_owner()) ? m_rdata : 32'h0);
            chk1 ("i_last",   i_last,   c_last && gi_owner());
            chk1 ("d_last",   d_last,   c_last && !gi_owner());
        end
    end

    // Owner of the current transaction, remembered at grant time.
    bit own_i;
    initial forever begin
        @(posedge clock or negedge reset);
        #0;
        if (!reset) own_i = 0;
        else if (gi) own_i = 1;
        else if (gd) own_i = 0;
    end
    function automatic bit gi_owner();
        return own_i;
    endfunction

    // ---------------- directed-test monitor ----------------
    logic [31:0] acc_log[$], wd_log[$];
    bit          gnt_log[$];
    int          gnt_cyc[$];
    int          cyc = 0, busy_cnt, stall_cnt, i_rv_cnt, d_rv_cnt, i_last_cnt, i_last_at;

    task automatic clr_logs();
        acc_log.delete(); wd_log.delete(); gnt_log.delete(); gnt_cyc.delete();
        busy_cnt = 0; stall_cnt = 0; i_rv_cnt = 0; d_rv_cnt = 0; i_last_cnt = 0; i_last_at = 0;
    endtask

    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            if (busy) busy_cnt++;
            if (m_valid && !m_ready) stall_cnt++;
            if (m_valid && m_ready) begin acc_log.push_back(m_addr); wd_log.push_back(m_wdata); end
            if (i_gnt) begin gnt_log.push_back(1'b0); gnt_cyc.push_back(cyc); end
            if (d_gnt) begin gnt_log.push_back(1'b1); gnt_cyc.push_back(cyc); end
            if (i_rvalid) begin
                i_rv_cnt++;
                if (i_last) begin i_last_cnt++; i_last_at = i_rv_cnt; end
            end
            if (d_rvalid) d_rv_cnt++;
        end
    end

    // ---------------- driver ----------------
    bit rand_mode = 0;
    bit d_persist = 0;

    task automatic step();
        @(posedge clock);
        #1;
        if (i_req && i_gnt) i_req = 1'b0;
        if (d_req && d_gnt && !d_persist) d_req = 1'b0;
        m_rdata = $urandom();
        if (rand_mode) begin
            m_ready  = ($urandom_range(0, 3) != 0);
            m_rvalid = $urandom_range(0, 1);
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1; i_addr = $urandom();
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = $urandom(); d_wdata = $urandom();
            end
        end
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk1 ({tag, "_busy"},     busy,     1'b0);
        chk1 ({tag, "_m_valid"},  m_valid,  1'b0);
        chk1 ({tag, "_m_we"},     m_we,     1'b0);
        chk32({tag, "_m_addr"},   m_addr,   32'h0);
        chk32({tag, "_m_wdata"},  m_wdata,  32'h0);
        chk1 ({tag, "_i_gnt"},    i_gnt,    1'b0);
        chk1 ({tag, "_d_gnt"},    d_gnt,    1'b0);
        chk1 ({tag, "_i_rvalid"}, i_rvalid, 1'b0);
        chk1 ({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        chk32({tag, "_i_rdata"},  i_rdata,  32'h0);
        chk32({tag, "_d_rdata"},  d_rdata,  32'h0);
        chk1 ({tag, "_i_last"},   i_last,   1'b0);
        chk1 ({tag, "_d_last"},   d_last,   1'b0);
    endtask

    // ---------------- test sequence ----------------
    logic [3:0] fair_order;
    bit         found;

    initial begin
        fair_order = FAIR ? 4'b0111 : 4'b1111;
        #2;
        check_outputs_zero("reset");
        steps(2);
        reset = 1'b1;

        // I line read, zero-wait memory.
        clr_logs();
        m_ready = 1'b1; m_rvalid = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_104C;
        steps(12);
        chk32("iread_acc_cnt", 32'(acc_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk32($sformatf("iread_addr%0d", k), acc_log[k], 32'h1040 + 32'(4 * k));
        chk32("iread_rvalid_cnt", 32'(i_rv_cnt), 32'd4);
        chk32("iread_last_cnt", 32'(i_last_cnt), 32'd1);
        chk32("iread_last_beat", 32'(i_last_at), 32'd4);
        chk32("iread_busy_cycles", 32'(busy_cnt), 32'd8);
        chk1 ("iread_idle_after", busy, 1'b0);

        // Tie: D wins, I follows after one IDLE cycle.
        clr_logs();
        i_req = 1'b1; i_addr = 32'h0000_5000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        steps(24);
        chk32("tie_gnt_cnt", 32'(gnt_log.size()), 32'd2);
        chk1 ("tie_first_d", gnt_log[0], 1'b1);
        chk1 ("tie_second_i", gnt_log[1], 1'b0);
        chk32("tie_gnt_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd9);
        chk32("tie_d_beats", 32'(d_rv_cnt), 32'd4);
        chk32("tie_d_addr0", acc_log[0], 32'h2000);

        // D write with 3 stall cycles; stray m_rvalid held high throughout.
        clr_logs();
        m_ready = 1'b0; m_rvalid = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3006; d_wdata = 32'hDEAD_BEEF;
        steps(4);
        m_ready = 1'b1;
        steps(3);
        chk32("wr_stall_cycles", 32'(stall_cnt), 32'd3);
        chk32("wr_accepts", 32'(acc_log.size()), 32'd1);
        chk32("wr_addr", acc_log[0], 32'h0000_3004);
        chk32("wr_data", wd_log[0], 32'hDEAD_BEEF);
        chk32("wr_no_rvalid", 32'(d_rv_cnt + i_rv_cnt), 32'd0);
        chk32("wr_busy_cycles", 32'(busy_cnt), 32'd4);
        chk1 ("wr_idle_after", busy, 1'b0);

        // Fairness: D requests continuously while I waits.
        clr_logs();
        d_persist = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_4000; d_wdata = 32'h1234_5678;
        i_req = 1'b1; i_addr = 32'h0000_6000;
        steps(14);
        chk1("fair_gnt_cnt", gnt_log.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++)
            chk1($sformatf("fair_gnt%0d_is_d", k), gnt_log[k], fair_order[k]);
        d_persist = 1'b0;
        steps(40);
        chk1("fair_drained", busy, 1'b0);

        // Reset during WAIT_R of beat 2.
        clr_logs();
        m_ready = 1'b1; m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_7010;
        found = 0;
        for (int s = 0; s < 40 && !found; s++) begin
            step();
            if (mwait && exp_q.size() == 1) found = 1;
            else m_rvalid = mwait;
        end
        chk1("abort_reached_beat2", found, 1'b1);
        #3;
        reset = 1'b0;
        m_rvalid = 1'b1;
        #1;
        check_outputs_zero("abort");
        steps(2);
        reset = 1'b1;
        clr_logs();
        steps(5);
        chk32("abort_no_rvalid", 32'(i_rv_cnt + d_rv_cnt), 32'd0);
        chk1 ("abort_idle", busy, 1'b0);

        // Stray m_rvalid pulse in IDLE.
        m_rvalid = 1'b0;
        step();
        m_rvalid = 1'b1;
        #3;
        chk1("stray_i_rvalid", i_rvalid, 1'b0);
        chk1("stray_d_rvalid", d_rvalid, 1'b0);
        chk1("stray_busy", busy, 1'b0);
        step();
        m_rvalid = 1'b0;
        #3;
        chk1("stray_busy_after", busy, 1'b0);

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        steps(3000);
        rand_mode = 1'b0;
        m_ready = 1'b1; m_rvalid = 1'b1;
        steps(80);
        chk1("final_idle", busy, 1'b0);
        chk1("final_no_pending_req", i_req || d_req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
